// File: rtl/dc1_xbit_fill.sv
// Write0-port sequencer for the D-cache x-bit array: merges store pbit updates with queued
// line-fill x-bit inserts. Macros: DCACHE_256K (AW=6), XBIT_FILL_PARITY_EN (fill parity check).
module dc1_xbit_fill #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 8,
`ifdef DCACHE_256K
  parameter int AW = 6
`else
  parameter int AW = 5
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_en,
  input  logic [AW+4:0] st_addrE,
  input  logic [AW+4:0] st_addrO,
  input  logic          st_odd,
  input  logic [1:0]    st_pbit,
  input  logic          st_d128,
  output logic          st_stall,
  input  logic          fill_en,
  input  logic [AW+4:0] fill_addr,
  input  logic          fill_odd,
  input  logic [15:0]   fill_xbits,
  input  logic          fill_par,
  output logic          fill_rdy,
  output logic          fill_perr,
  output logic          wr0_clkEn,
  output logic [AW+4:0] wr0_addrE,
  output logic [AW+4:0] wr0_addrO,
  output logic          wr0_odd,
  output logic [1:0]    wr0_pbit,
  output logic          wr0_d128,
  output logic [1:0]    wr_ins,
  output logic [15:0]   wr_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [0:0] NORM  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [AW+4:0]         addr_mem [FIFO_DEPTH];
  logic [15:0]           data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] odd_reg, vld_reg;
  logic [PW-1:0]         rd_ptr_reg, wr_ptr_reg;
  logic [PW:0]           count_reg;
  logic [CW-1:0]         starve_reg;
  logic [0:0]            state_reg, state_next;

  logic                  empty, full, enq, hit, starve;
  logic                  norm_store, norm_fill, do_store, do_fill;
  logic [AW-1:0]         st_idx;
  logic [FIFO_DEPTH-1:0] match;
  logic [15:0]           enq_data;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (PW+1)'(FIFO_DEPTH));
  assign fill_rdy = ~full;
  assign enq      = fill_en && ~full;
  assign st_idx   = st_odd ? st_addrO[AW+3:4] : st_addrE[AW+3:4];

  // A store must not overtake any queued fill for the same line index and bank.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
      assign match[gi] = vld_reg[gi] && (odd_reg[gi] == st_odd) &&
                         (addr_mem[gi][AW+3:4] == st_idx);
    end
  endgenerate

  assign hit        = st_en && (|match);
  assign starve     = (starve_reg >= CW'(STARVE_LIM)) && ~empty;
  assign norm_store = st_en && ~hit && ~starve;
  assign norm_fill  = ~norm_store && ~empty;

  always_comb begin
    do_store   = norm_store;
    do_fill    = norm_fill;
    state_next = state_reg;
    case (state_reg)
      NORM: begin
        if (hit) state_next = DRAIN;
      end
      DRAIN: begin
        // Stay draining only while the held store still collides with a queued fill.
        if (hit) begin
          do_store = 1'b0;
          do_fill  = 1'b1;
        end else begin
          state_next = NORM;
        end
      end
      default: state_next = NORM;
    endcase
  end

  assign st_stall = st_en && ~do_store;

`ifdef XBIT_FILL_PARITY_EN
  logic par_bad, perr_reg;
  assign par_bad  = (fill_par != ^fill_xbits);
  assign enq_data = par_bad ? 16'h0000 : fill_xbits;
  assign fill_perr = perr_reg;
  always_ff @(posedge clk) begin
    if (rst) perr_reg <= 1'b0;
    else     perr_reg <= enq && par_bad;
  end
`else
  logic unused_par;
  assign unused_par = fill_par;
  assign enq_data   = fill_xbits;
  assign fill_perr  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= fill_addr;
      data_mem[wr_ptr_reg] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg    <= '0;
      odd_reg    <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      state_reg  <= NORM;
      wr0_clkEn  <= 1'b0;
      wr0_addrE  <= '0;
      wr0_addrO  <= '0;
      wr0_odd    <= 1'b0;
      wr0_pbit   <= '0;
      wr0_d128   <= 1'b0;
      wr_ins     <= '0;
      wr_data    <= '0;
    end else begin
      state_reg <= state_next;
      if (enq) begin
        vld_reg[wr_ptr_reg] <= 1'b1;
        odd_reg[wr_ptr_reg] <= fill_odd;
        wr_ptr_reg          <= wr_ptr_reg + PW'(1);
      end
      if (do_fill) begin
        vld_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg          <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + (PW+1)'(enq) - (PW+1)'(do_fill);

      if (do_fill)                starve_reg <= '0;
      else if (do_store && ~empty) starve_reg <= starve_reg + CW'(1);

      wr0_clkEn <= 1'b0;
      wr0_addrE <= '0;
      wr0_addrO <= '0;
      wr0_odd   <= 1'b0;
      wr0_pbit  <= '0;
      wr0_d128  <= 1'b0;
      wr_ins    <= '0;
      wr_data   <= '0;
      if (do_store) begin
        wr0_clkEn <= 1'b1;
        wr0_addrE <= st_addrE;
        wr0_addrO <= st_addrO;
        wr0_odd   <= st_odd;
        wr0_pbit  <= st_pbit;
        wr0_d128  <= st_d128;
      end else if (do_fill) begin
        wr0_addrE <= addr_mem[rd_ptr_reg];
        wr0_addrO <= addr_mem[rd_ptr_reg];
        wr0_odd   <= odd_reg[rd_ptr_reg];
        wr_ins    <= odd_reg[rd_ptr_reg] ? 2'b10 : 2'b01;
        wr_data   <= data_mem[rd_ptr_reg];
      end
    end
  end
endmodule

// File: tb/tb_dc1_xbit_fill.sv
// Bench for dc1_xbit_fill: directed scenarios plus random traffic checked against a
// queue-based model of the fill buffer, hazard ordering and starvation rule.
module tb_dc1_xbit_fill;
`ifdef DCACHE_256K
  localparam int AW = 6;
`else
  localparam int AW = 5;
`endif
  localparam int A     = AW + 5;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;
  localparam int BW    = 2 * AW + 33;

  logic          clk = 1'b0, rst = 1'b1;
  logic          st_en = 1'b0, st_odd = 1'b0, st_d128 = 1'b0;
  logic [A-1:0]  st_addrE = '0, st_addrO = '0;
  logic [1:0]    st_pbit = '0;
  logic          fill_en = 1'b0, fill_odd = 1'b0, fill_par = 1'b0;
  logic [A-1:0]  fill_addr = '0;
  logic [15:0]   fill_xbits = '0;
  logic          st_stall, fill_rdy, fill_perr, wr0_clkEn, wr0_odd, wr0_d128;
  logic [A-1:0]  wr0_addrE, wr0_addrO;
  logic [1:0]    wr0_pbit, wr_ins;
  logic [15:0]   wr_data;
  logic [BW-1:0] bus;

  dc1_xbit_fill #(.FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .st_en(st_en), .st_addrE(st_addrE), .st_addrO(st_addrO), .st_odd(st_odd),
    .st_pbit(st_pbit), .st_d128(st_d128), .st_stall(st_stall),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_odd(fill_odd),
    .fill_xbits(fill_xbits), .fill_par(fill_par), .fill_rdy(fill_rdy), .fill_perr(fill_perr),
    .wr0_clkEn(wr0_clkEn), .wr0_addrE(wr0_addrE), .wr0_addrO(wr0_addrO), .wr0_odd(wr0_odd),
    .wr0_pbit(wr0_pbit), .wr0_d128(wr0_d128), .wr_ins(wr_ins), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  assign bus = {wr0_clkEn, wr0_addrE, wr0_addrO, wr0_odd, wr0_pbit, wr0_d128, wr_ins, wr_data};

  typedef struct packed {
    logic [A-1:0] addr;
    logic         odd;
    logic [15:0]  data;
  } fent_t;

  fent_t mq[$];
  int    m_starve = 0;
  logic  m_stall = 1'b0, m_accept = 1'b0;
  logic  dut_stall, dut_rdy;
  int    n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_store(input logic en, input logic [A-1:0] ae, input logic [A-1:0] ao,
                           input logic odd, input logic [1:0] pb, input logic d128);
    st_en = en; st_addrE = ae; st_addrO = ao; st_odd = odd; st_pbit = pb; st_d128 = d128;
  endtask

  task automatic set_fill(input logic en, input logic [A-1:0] a, input logic odd,
                          input logic [15:0] x, input logic flip_par);
    fill_en = en; fill_addr = a; fill_odd = odd; fill_xbits = x; fill_par = (^x) ^ flip_par;
  endtask

  // One clock: model the decision from the spec rules, then compare the registered result.
  task automatic cycle();
    logic [AW-1:0] idx;
    logic          hit, starving, store_go, fill_go, bad, exp_perr;
    logic [BW-1:0] exp;
    fent_t         h;
    @(negedge clk);
    dut_stall = st_stall;
    dut_rdy   = fill_rdy;
    idx = st_odd ? st_addrO[AW+3:4] : st_addrE[AW+3:4];
    hit = 1'b0;
    foreach (mq[i])
      if (st_en && mq[i].odd == st_odd && mq[i].addr[AW+3:4] == idx) hit = 1'b1;
    starving = (m_starve >= LIM) && (mq.size() > 0);
    store_go = st_en && !hit && !starving;
    fill_go  = !store_go && (mq.size() > 0);
    m_stall  = st_en && !store_go;
    m_accept = fill_en && (mq.size() < DEPTH);
    check("st_stall", st_stall, m_stall);
    check("fill_rdy", fill_rdy, mq.size() < DEPTH);
    exp = '0;
    if (store_go) begin
      exp = {1'b1, st_addrE, st_addrO, st_odd, st_pbit, st_d128, 2'b00, 16'h0000};
      if (mq.size() > 0) m_starve++;
    end else if (fill_go) begin
      h = mq.pop_front();
      exp = {1'b0, h.addr, h.addr, h.odd, 2'b00, 1'b0, (h.odd ? 2'b10 : 2'b01), h.data};
      m_starve = 0;
    end
    bad = 1'b0;
`ifdef XBIT_FILL_PARITY_EN
    bad = (fill_par != ^fill_xbits);
`endif
    if (m_accept) mq.push_back({fill_addr, fill_odd, (bad ? 16'h0000 : fill_xbits)});
    exp_perr = m_accept && bad;
    @(posedge clk);
    #1;
    check("wr_bus", bus, exp);
    check("fill_perr", fill_perr, exp_perr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_store(0, '0, '0, 0, 2'b00, 0);
    set_fill(0, '0, 0, 16'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_accept = 1'b0;
    check("rst_bus", bus, '0);
    check("rst_rdy", fill_rdy, 1'b1);
    check("rst_perr", fill_perr, 1'b0);
    check("rst_stall", st_stall, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_stall, n_stall, n_fill, rdy_c4, s2, s3, s4;
    logic [15:0] d2, d3;
    logic [15:0] src[$];
    logic [15:0] got[$];
    logic [15:0] want[$];

    do_reset();
    $display("reset: outputs idle, fill_rdy=%0d", fill_rdy);

    // Single store passes straight through
    set_store(1, A'(32'h040), A'(32'h000), 0, 2'b10, 0);
    cycle();
    check("t1_clken", wr0_clkEn, 1'b1);
    check("t1_pbit", wr0_pbit, 2'b10);
    check("t1_ins", wr_ins, 2'b00);
    check("t1_addrE", wr0_addrE, A'(32'h040));
    set_store(0, '0, '0, 0, 2'b00, 0);
    $display("store: addrE=%0h pbit=%0b", wr0_addrE, wr0_pbit);

    // Single fill, minimum latency
    set_fill(1, A'(32'h120), 1, 16'hA5C3, 0);
    cycle();
    set_fill(0, '0, 0, 16'h0, 0);
    cycle();
    check("t2_ins", wr_ins, 2'b10);
    check("t2_data", wr_data, 16'hA5C3);
    check("t2_addrO", wr0_addrO, A'(32'h120));
    check("t2_clken", wr0_clkEn, 1'b0);
    $display("fill: ins=%0b data=%0h addrO=%0h", wr_ins, wr_data, wr0_addrO);

    // Starvation: four fills under continuous unrelated stores
    first_stall = -1; n_stall = 0; n_fill = 0; rdy_c4 = -1;
    for (int c = 0; c < 13; c++) begin
      set_store(1, A'(32'h1F0), A'(32'h1F0), 0, 2'b01, 0);
      if (c < 4) set_fill(1, A'(c << 4), 1, 16'h1000 + 16'(c), 0);
      else       set_fill(0, '0, 0, 16'h0, 0);
      cycle();
      if (dut_stall) begin
        n_stall++;
        if (first_stall < 0) first_stall = c;
      end
      if (wr_ins != 2'b00) n_fill++;
      if (c == 4) rdy_c4 = int'(dut_rdy);
    end
    check("t3_full_rdy", rdy_c4, 0);
    check("t3_first_stall", first_stall, 9);
    check("t3_stall_count", n_stall, 1);
    check("t3_fill_count", n_fill, 1);
    set_store(0, '0, '0, 0, 2'b00, 0);
    repeat (5) cycle();
    $display("starve: first stall at cycle %0d, stalls=%0d", first_stall, n_stall);

    // Hazard: store to a queued line waits until that fill has issued
    set_store(1, A'(32'h1F0), A'(32'h1F0), 0, 2'b01, 0);
    set_fill(1, A'(32'h050), 0, 16'h0A5A, 0);
    cycle();
    set_fill(1, A'(32'h120), 1, 16'hBEEF, 0);
    cycle();
    set_fill(0, '0, 0, 16'h0, 0);
    set_store(1, A'(32'h000), A'(32'h120), 1, 2'b11, 1);
    cycle(); s2 = int'(dut_stall); d2 = wr_data;
    cycle(); s3 = int'(dut_stall); d3 = wr_data;
    cycle(); s4 = int'(dut_stall);
    check("t4_stall_a", s2, 1);
    check("t4_stall_b", s3, 1);
    check("t4_stall_c", s4, 0);
    check("t4_data_first", d2, 16'h0A5A);
    check("t4_data_match", d3, 16'hBEEF);
    check("t4_store_clken", wr0_clkEn, 1'b1);
    check("t4_store_addrO", wr0_addrO, A'(32'h120));
    check("t4_store_d128", wr0_d128, 1'b1);
    set_store(0, '0, '0, 0, 2'b00, 0);
    cycle();
    $display("hazard: stalls=%0d%0d%0d order=%0h,%0h", s2, s3, s4, d2, d3);

    // Full FIFO with a held fill while a dequeue happens: order preserved, nothing lost
    src = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    want = src;
    got.delete();
    rdy_c4 = -1;
    for (int c = 0; c < 15; c++) begin
      if (c < 4) set_store(1, A'(32'h1F0), A'(32'h1F0), 0, 2'b01, 0);
      else       set_store(0, '0, '0, 0, 2'b00, 0);
      if (src.size() > 0) set_fill(1, A'((c + 8) << 4), 1, src[0], 0);
      else                set_fill(0, '0, 0, 16'h0, 0);
      cycle();
      if (m_accept) void'(src.pop_front());
      if (c == 4) rdy_c4 = int'(dut_rdy);
      if (wr_ins != 2'b00) got.push_back(wr_data);
    end
    check("t5_full_rdy", rdy_c4, 0);
    check("t5_count", got.size(), 5);
    foreach (want[i])
      check("t5_order", (i < got.size()) ? got[i] : 16'hxxxx, want[i]);
    $display("full: issued %0d fills in order", got.size());

    // Parity error on a fill
    set_fill(1, A'(32'h070), 0, 16'h0001, 1);
    cycle();
`ifdef XBIT_FILL_PARITY_EN
    check("t6_perr", fill_perr, 1'b1);
`else
    check("t6_perr", fill_perr, 1'b0);
`endif
    set_fill(0, '0, 0, 16'h0, 0);
    cycle();
    check("t6_ins", wr_ins, 2'b01);
`ifdef XBIT_FILL_PARITY_EN
    check("t6_data", wr_data, 16'h0000);
`else
    check("t6_data", wr_data, 16'h0001);
`endif
    $display("parity: data=%0h", wr_data);

    // Reset while fills are queued discards them
    for (int c = 0; c < 3; c++) begin
      set_store(1, A'(32'h1F0), A'(32'h1F0), 0, 2'b01, 0);
      set_fill(1, A'(c << 4), 1, 16'h7000 + 16'(c), 0);
      cycle();
    end
    do_reset();
    n_fill = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (wr_ins != 2'b00) n_fill++;
    end
    check("t7_no_fills", n_fill, 0);
    $display("reset mid-drain: fills after reset=%0d", n_fill);

    // Random traffic against the model; stalled stores and refused fills are held
    n_fill = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!m_stall) begin
        st_en    = ($urandom_range(0, 99) < 60);
        st_odd   = 1'($urandom);
        st_addrE = A'($urandom);
        st_addrO = A'($urandom);
        st_addrE[AW+3:4] = AW'($urandom_range(0, 3));
        st_addrO[AW+3:4] = AW'($urandom_range(0, 3));
        st_pbit  = 2'($urandom);
        st_d128  = 1'($urandom);
      end
      if (!(fill_en && !m_accept)) begin
        logic [A-1:0] fa;
        fa = A'($urandom);
        fa[AW+3:4] = AW'($urandom_range(0, 3));
        set_fill(($urandom_range(0, 99) < 35), fa, 1'($urandom), 16'($urandom),
                 ($urandom_range(0, 7) == 0));
      end
      cycle();
      if (wr_ins != 2'b00) n_fill++;
    end
    $display("random: 1500 cycles, %0d fills issued", n_fill);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
